// File: rtl/dsp48e1_model_pkg.sv
// Shared encodings for the DSP48E1 behavioural slice:
// OPMODE mux selects, ALUMODE/CARRYINSEL codes and SIMD lane widths.
package dsp48e1_model_pkg;

    localparam logic [1:0] OPX_ZERO = 2'b00;
    localparam logic [1:0] OPX_M    = 2'b01;
    localparam logic [1:0] OPX_P    = 2'b10;
    localparam logic [1:0] OPX_AB   = 2'b11;

    localparam logic [1:0] OPY_ZERO = 2'b00;
    localparam logic [1:0] OPY_M    = 2'b01;
    localparam logic [1:0] OPY_ONES = 2'b10;
    localparam logic [1:0] OPY_C    = 2'b11;

    localparam logic [2:0] OPZ_ZERO  = 3'b000;
    localparam logic [2:0] OPZ_PCIN  = 3'b001;
    localparam logic [2:0] OPZ_P     = 3'b010;
    localparam logic [2:0] OPZ_C     = 3'b011;
    localparam logic [2:0] OPZ_P_ALT = 3'b100;
    localparam logic [2:0] OPZ_PC17  = 3'b101;
    localparam logic [2:0] OPZ_P17   = 3'b110;
    localparam logic [2:0] OPZ_PA17  = 3'b111;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_NZADD  = 4'b0001;
    localparam logic [3:0] ALU_NOTADD = 4'b0010;
    localparam logic [3:0] ALU_ZSUB   = 4'b0011;

    localparam logic [2:0] CISEL_CARRYIN = 3'b000;

    localparam int SIMD_W_ONE48  = 48;
    localparam int SIMD_W_TWO24  = 24;
    localparam int SIMD_W_FOUR12 = 12;
    localparam int P_W           = 48;
    localparam int CO_W          = 4;

endpackage

// File: rtl/dsp48e1_model_alu.sv
// One SIMD lane of the post-adder: Z, X+Y+CIN combined according to
// ALUMODE, with a lane-local carry/borrow indication.
module dsp_lane_alu
    import dsp48e1_model_pkg::*;
#(
    parameter int W = 48
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_z,
    input  logic         i_cin,
    input  logic [3:0]   i_alumode,
    output logic [W-1:0] o_res,
    output logic         o_cout
);

    logic [W+1:0] w_xyc;
    logic [W+1:0] w_zx;
    logic [W+1:0] w_sum;
    logic [W-1:0] w_diff;

    always_comb begin
        w_xyc  = {2'b00, i_x} + {2'b00, i_y} + {{(W + 1){1'b0}}, i_cin};
        w_zx   = {2'b00, i_z};
        w_sum  = w_zx + w_xyc;
        w_diff = i_z - w_xyc[W-1:0];
        o_res  = w_sum[W-1:0];
        o_cout = |w_sum[W+1:W];
        unique case (i_alumode)
            ALU_ZSUB: begin
                o_res  = w_diff;
                // Carry reads as "no borrow" for subtraction
                o_cout = (w_zx >= w_xyc);
            end
            ALU_NZADD: begin
                o_res  = ~i_z + w_xyc[W-1:0];
                o_cout = 1'b0;
            end
            ALU_NOTADD: begin
                o_res = ~w_sum[W-1:0];
            end
            default: begin
                o_res  = w_sum[W-1:0];
                o_cout = |w_sum[W+1:W];
            end
        endcase
    end

endmodule

// File: rtl/dsp48e1_model.sv
// Behavioural DSP48E1 subset: A:B/C/P operand muxes, SIMD lane ALU,
// optional input/carry/output registers. Multiplier and D path absent.
module dsp48e1_model
    import dsp48e1_model_pkg::*;
#(
    parameter int    AREG               = 1,
    parameter int    BREG               = 1,
    parameter int    CREG               = 1,
    parameter int    PREG               = 1,
    parameter int    CARRYINREG         = 1,
    parameter string USE_SIMD           = "ONE48",
    parameter int    DREG               = 1,
    parameter int    ADREG              = 1,
    parameter int    MREG               = 1,
    parameter int    INMODEREG          = 1,
    parameter string USE_MULT           = "NONE",
    parameter string USE_PATTERN_DETECT = "NO_PATDET"
) (
    input  logic        CLK,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTP,
    input  logic        RSTALLCARRYIN,
    input  logic [29:0] A,
    input  logic [17:0] B,
    input  logic [47:0] C,
    input  logic [24:0] D,
    input  logic [4:0]  INMODE,
    input  logic        CEA2,
    input  logic        CEB2,
    input  logic        CEC,
    input  logic        CEP,
    input  logic        CECARRYIN,
    input  logic [6:0]  OPMODE,
    input  logic [3:0]  ALUMODE,
    input  logic [2:0]  CARRYINSEL,
    input  logic        CARRYIN,
    output logic [47:0] P,
    output logic [3:0]  CARRYOUT
);

    localparam int LW =
        (USE_SIMD == "FOUR12") ? SIMD_W_FOUR12 :
        (USE_SIMD == "TWO24")  ? SIMD_W_TWO24  : SIMD_W_ONE48;
    localparam int NL      = P_W / LW;
    localparam int CO_STEP = CO_W / NL;

    logic [29:0]     w_a;
    logic [17:0]     w_b;
    logic [47:0]     w_c;
    logic            w_carryin;
    logic [P_W-1:0]  w_pfb;
    logic [P_W-1:0]  w_x;
    logic [P_W-1:0]  w_y;
    logic [P_W-1:0]  w_z;
    logic            w_cin;
    logic [P_W-1:0]  w_res;
    logic [NL-1:0]   w_lane_co;
    logic [CO_W-1:0] w_co;
    logic            w_unused;

    assign w_unused = ^{D, INMODE, CEA2, CEB2, CEC, CEP, CECARRYIN,
                        RSTA, RSTB, RSTC, RSTP, RSTALLCARRYIN,
                        (DREG != 0), (ADREG != 0), (MREG != 0),
                        (INMODEREG != 0), (USE_MULT == ""),
                        (USE_PATTERN_DETECT == "")};

    if (AREG != 0) begin : g_areg
        logic [29:0] r_a;
        always_ff @(posedge CLK) begin
            if (RSTA)      r_a <= '0;
            else if (CEA2) r_a <= A;
        end
        assign w_a = r_a;
    end else begin : g_acomb
        assign w_a = A;
    end

    if (BREG != 0) begin : g_breg
        logic [17:0] r_b;
        always_ff @(posedge CLK) begin
            if (RSTB)      r_b <= '0;
            else if (CEB2) r_b <= B;
        end
        assign w_b = r_b;
    end else begin : g_bcomb
        assign w_b = B;
    end

    if (CREG != 0) begin : g_creg
        logic [47:0] r_c;
        always_ff @(posedge CLK) begin
            if (RSTC)     r_c <= '0;
            else if (CEC) r_c <= C;
        end
        assign w_c = r_c;
    end else begin : g_ccomb
        assign w_c = C;
    end

    if (CARRYINREG != 0) begin : g_cireg
        logic r_carryin;
        always_ff @(posedge CLK) begin
            if (RSTALLCARRYIN)  r_carryin <= 1'b0;
            else if (CECARRYIN) r_carryin <= CARRYIN;
        end
        assign w_carryin = r_carryin;
    end else begin : g_cicomb
        assign w_carryin = CARRYIN;
    end

    always_comb begin
        unique case (OPMODE[1:0])
            OPX_P:   w_x = w_pfb;
            OPX_AB:  w_x = {w_a, w_b};
            default: w_x = '0;
        endcase
        unique case (OPMODE[3:2])
            OPY_ONES: w_y = '1;
            OPY_C:    w_y = w_c;
            default:  w_y = '0;
        endcase
        unique case (OPMODE[6:4])
            OPZ_P, OPZ_P_ALT: w_z = w_pfb;
            OPZ_C:            w_z = w_c;
            OPZ_P17:          w_z = P_W'($signed(w_pfb) >>> 17);
            default:          w_z = '0;
        endcase
        w_cin = (CARRYINSEL == CISEL_CARRYIN) ? w_carryin : 1'b0;
    end

    // Lanes are independent; carry-in only enters the lowest lane
    for (genvar n = 0; n < NL; n++) begin : g_lane
        dsp_lane_alu #(
            .W(LW)
        ) u_alu (
            .i_x       (w_x[n*LW +: LW]),
            .i_y       (w_y[n*LW +: LW]),
            .i_z       (w_z[n*LW +: LW]),
            .i_cin     ((n == 0) ? w_cin : 1'b0),
            .i_alumode (ALUMODE),
            .o_res     (w_res[n*LW +: LW]),
            .o_cout    (w_lane_co[n])
        );
    end

    always_comb begin
        w_co = '0;
        for (int n = 0; n < NL; n++) begin
            w_co[(n + 1) * CO_STEP - 1] = w_lane_co[n];
        end
    end

    if (PREG != 0) begin : g_preg
        logic [P_W-1:0]  r_p;
        logic [CO_W-1:0] r_co;
        always_ff @(posedge CLK) begin
            if (RSTP) begin
                r_p  <= '0;
                r_co <= '0;
            end else if (CEP) begin
                r_p  <= w_res;
                r_co <= w_co;
            end
        end
        assign P        = r_p;
        assign CARRYOUT = r_co;
        assign w_pfb    = r_p;
    end else begin : g_pcomb
        // Without the P register there is no state to feed back
        assign P        = w_res;
        assign CARRYOUT = w_co;
        assign w_pfb    = '0;
    end

endmodule

// File: tb/tb_dsp48e1_model.sv
// Directed bench: three SIMD configurations share one stimulus bus,
// table vectors for the ALU plus hand-written accumulate sequences.
module tb_dsp48e1_model;

    logic        CLK = 1'b0;
    logic        RSTA = 0, RSTB = 0, RSTC = 0, RSTP = 0, RSTALLCARRYIN = 0;
    logic [29:0] A = '0;
    logic [17:0] B = '0;
    logic [47:0] C = '0;
    logic [24:0] D = '0;
    logic [4:0]  INMODE = '0;
    logic        CEA2 = 1, CEB2 = 1, CEC = 1, CEP = 1, CECARRYIN = 1;
    logic [6:0]  OPMODE = '0;
    logic [3:0]  ALUMODE = '0;
    logic [2:0]  CARRYINSEL = '0;
    logic        CARRYIN = 0;
    logic [47:0] P1, P2, P4;
    logic [3:0]  CO1, CO2, CO4;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    dsp48e1_model #(.USE_SIMD("ONE48")) u1 (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTP(RSTP),
        .RSTALLCARRYIN(RSTALLCARRYIN), .A(A), .B(B), .C(C), .D(D),
        .INMODE(INMODE), .CEA2(CEA2), .CEB2(CEB2), .CEC(CEC), .CEP(CEP),
        .CECARRYIN(CECARRYIN), .OPMODE(OPMODE), .ALUMODE(ALUMODE),
        .CARRYINSEL(CARRYINSEL), .CARRYIN(CARRYIN), .P(P1), .CARRYOUT(CO1)
    );

    dsp48e1_model #(.USE_SIMD("TWO24")) u2 (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTP(RSTP),
        .RSTALLCARRYIN(RSTALLCARRYIN), .A(A), .B(B), .C(C), .D(D),
        .INMODE(INMODE), .CEA2(CEA2), .CEB2(CEB2), .CEC(CEC), .CEP(CEP),
        .CECARRYIN(CECARRYIN), .OPMODE(OPMODE), .ALUMODE(ALUMODE),
        .CARRYINSEL(CARRYINSEL), .CARRYIN(CARRYIN), .P(P2), .CARRYOUT(CO2)
    );

    dsp48e1_model #(.USE_SIMD("FOUR12")) u4 (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTP(RSTP),
        .RSTALLCARRYIN(RSTALLCARRYIN), .A(A), .B(B), .C(C), .D(D),
        .INMODE(INMODE), .CEA2(CEA2), .CEB2(CEB2), .CEC(CEC), .CEP(CEP),
        .CECARRYIN(CECARRYIN), .OPMODE(OPMODE), .ALUMODE(ALUMODE),
        .CARRYINSEL(CARRYINSEL), .CARRYIN(CARRYIN), .P(P4), .CARRYOUT(CO4)
    );

    typedef struct {
        logic [6:0]  opm;
        logic [3:0]  alu;
        logic [2:0]  cisel;
        logic        cin;
        logic [47:0] ab;
        logic [47:0] c;
        logic [47:0] p1;
        logic [3:0]  co1;
        logic [47:0] p2;
        logic [3:0]  co2;
        logic [47:0] p4;
        logic [3:0]  co4;
    } vec_t;

    vec_t vt[9];

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [47:0] got,
                       input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    localparam logic [47:0] INC2 = 48'h000001_000001;

    initial begin
        vt[0] = '{7'b0110011, 4'b0011, 3'b000, 1'b0, 48'h3, 48'd10,
                  48'h7, 4'b1000, 48'h7, 4'b1010, 48'h7, 4'b1111};
        vt[1] = '{7'b0110011, 4'b0011, 3'b000, 1'b0, 48'd11, 48'd10,
                  48'hFFFF_FFFF_FFFF, 4'b0000, 48'h0000_00FF_FFFF, 4'b1000,
                  48'h0000_0000_0FFF, 4'b1110};
        vt[2] = '{7'b0110011, 4'b0000, 3'b000, 1'b0, 48'h1,
                  48'h000000_FFFFFF,
                  48'h000001_000000, 4'b0000, 48'h0, 4'b0010,
                  48'h000000_FFF000, 4'b0001};
        vt[3] = '{7'b0110011, 4'b0010, 3'b000, 1'b0, 48'h1234_5678_9ABC,
                  48'h0,
                  48'hEDCB_A987_6543, 4'b0000, 48'hEDCB_A987_6543, 4'b0000,
                  48'hEDCB_A987_6543, 4'b0000};
        vt[4] = '{7'b0001000, 4'b0000, 3'b000, 1'b1, 48'h0, 48'h0,
                  48'h0, 4'b1000, 48'hFFFFFF_000000, 4'b0010,
                  48'hFFFF_FFFF_F000, 4'b0001};
        vt[5] = '{7'b0001000, 4'b0000, 3'b001, 1'b1, 48'h0, 48'h0,
                  48'hFFFF_FFFF_FFFF, 4'b0000, 48'hFFFF_FFFF_FFFF, 4'b0000,
                  48'hFFFF_FFFF_FFFF, 4'b0000};
        vt[6] = '{7'b0110011, 4'b0001, 3'b000, 1'b0, 48'd8, 48'd5,
                  48'h2, 4'b0000, 48'hFFFFFF_000002, 4'b0000,
                  48'hFFFF_FFFF_F002, 4'b0000};
        vt[7] = '{7'b0110011, 4'b0111, 3'b000, 1'b0, 48'h23, 48'h100,
                  48'h123, 4'b0000, 48'h123, 4'b0000, 48'h123, 4'b0000};
        vt[8] = '{7'b0001100, 4'b0000, 3'b000, 1'b0, 48'h0,
                  48'hABCD_EF01_2345,
                  48'hABCD_EF01_2345, 4'b0000, 48'hABCD_EF01_2345, 4'b0000,
                  48'hABCD_EF01_2345, 4'b0000};

        RSTA = 1; RSTB = 1; RSTC = 1; RSTP = 1; RSTALLCARRYIN = 1;
        step(1);
        RSTA = 0; RSTB = 0; RSTC = 0; RSTP = 0; RSTALLCARRYIN = 0;
        chk("rst_p1", P1, 48'h0);
        chk("rst_co1", {44'h0, CO1}, 48'h0);
        chk("rst_p2", P2, 48'h0);
        chk("rst_co2", {44'h0, CO2}, 48'h0);
        chk("rst_p4", P4, 48'h0);
        chk("rst_co4", {44'h0, CO4}, 48'h0);

        for (int i = 0; i < 9; i++) begin
            OPMODE     = vt[i].opm;
            ALUMODE    = vt[i].alu;
            CARRYINSEL = vt[i].cisel;
            CARRYIN    = vt[i].cin;
            {A, B}     = vt[i].ab;
            C          = vt[i].c;
            step(2);
            chk($sformatf("vec%0d_p1", i), P1, vt[i].p1);
            chk($sformatf("vec%0d_co1", i), {44'h0, CO1}, {44'h0, vt[i].co1});
            chk($sformatf("vec%0d_p2", i), P2, vt[i].p2);
            chk($sformatf("vec%0d_co2", i), {44'h0, CO2}, {44'h0, vt[i].co2});
            chk($sformatf("vec%0d_p4", i), P4, vt[i].p4);
            chk($sformatf("vec%0d_co4", i), {44'h0, CO4}, {44'h0, vt[i].co4});
        end
        ALUMODE = 4'b0000; CARRYINSEL = 3'b000; CARRYIN = 0;

        OPMODE = 7'b0000011;
        {A, B} = 48'h8000_0000_0000;
        step(2);
        chk("shift_load", P1, 48'h8000_0000_0000);
        OPMODE = 7'b1100000;
        step(1);
        chk("shift_p17", P1, 48'hFFFF_C000_0000);

        RSTP = 1; RSTC = 1; C = '0; OPMODE = 7'b0101100;
        step(1);
        RSTP = 0; RSTC = 0;
        chk("cnt_rst", P2, 48'h0);
        C = INC2;
        step(1);
        chk("cnt_lat", P2, 48'h0);
        for (int i = 1; i <= 4; i++) begin
            step(1);
            chk($sformatf("cnt%0d", i), P2, INC2 * i);
        end

        RSTP = 1;
        step(1);
        RSTP = 0;
        chk("rstp_mid_p", P2, 48'h0);
        chk("rstp_mid_co", {44'h0, CO2}, 48'h0);
        step(1);
        chk("cnt_after_rst", P2, INC2);
        CEP = 0;
        step(2);
        chk("cep_hold_p2", P2, INC2);
        chk("cep_hold_p1", P1, INC2);
        CEP = 1;

        OPMODE = 7'b0000011;
        {A, B} = 48'h000005_FFFFFF;
        step(2);
        chk("wrap_load", P2, 48'h000005_FFFFFF);
        OPMODE = 7'b0101100;
        step(1);
        chk("wrap_p", P2, 48'h000006_000000);
        chk("wrap_co", {44'h0, CO2}, 48'h2);
        step(1);
        chk("wrap_next_p", P2, 48'h000007_000001);
        chk("wrap_next_co", {44'h0, CO2}, 48'h0);

        OPMODE = 7'b0000011;
        {A, B} = 48'h000000_FFFFFF;
        C = 48'h1;
        step(2);
        OPMODE = 7'b0101100;
        step(1);
        chk("one48_p", P1, 48'h000001_000000);
        chk("one48_co", {44'h0, CO1}, 48'h0);

        OPMODE = 7'b0000011;
        {A, B} = 48'h000F_FF00_0000;
        C = 48'h0010_0100_1001;
        step(2);
        OPMODE = 7'b0101100;
        step(1);
        chk("four12_p", P4, 48'h0010_0000_1001);
        chk("four12_co", {44'h0, CO4}, 48'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
